fir_filter: RTL and testbench

FIR_FILTER -- requirements
Module: fir_filter

---
 rtl/fir_filter_if.sv | 44 ++++
 rtl/fir_filter.sv | 241 ++++++++++++++++++++++++
 tb/tb_fir_filter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fir_filter_if.sv
//==============================================================================
// Module   : fir_filter_if
// Brief    : AXI-Lite, AXI-Stream and tap/sample RAM signals of fir_filter.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface fir_filter_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                   awvalid, awready, wvalid, wready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid, arready, rvalid, rready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic [pDATA_WIDTH-1:0] rdata;
  logic                   ss_tvalid, ss_tlast, ss_tready;
  logic [pDATA_WIDTH-1:0] ss_tdata;
  logic                   sm_tvalid, sm_tlast, sm_tready;
  logic [pDATA_WIDTH-1:0] sm_tdata;
  logic [3:0]             tap_WE, data_WE;
  logic                   tap_EN, data_EN;
  logic [pDATA_WIDTH-1:0] tap_Di, tap_Do, data_Di, data_Do;
  logic [pADDR_WIDTH-1:0] tap_A, data_A;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
           ss_tvalid, ss_tdata, ss_tlast, sm_tready, tap_Do, data_Do,
    output awready, wready, arready, rvalid, rdata, ss_tready,
           sm_tvalid, sm_tdata, sm_tlast,
           tap_WE, tap_EN, tap_Di, tap_A, data_WE, data_EN, data_Di, data_A
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
           ss_tvalid, ss_tdata, ss_tlast, sm_tready, tap_Do, data_Do,
    input  awready, wready, arready, rvalid, rdata, ss_tready,
           sm_tvalid, sm_tdata, sm_tlast,
           tap_WE, tap_EN, tap_Di, tap_A, data_WE, data_EN, data_Di, data_A
  );
endinterface

`default_nettype wire

// File: rtl/fir_filter.sv
//==============================================================================
// Module   : fir_filter
// Brief    : 11-tap FIR with AXI-Lite control/taps and AXI-Stream data path.
//            Define FIR_TAP_LOCK_EN to drop tap writes while the engine runs.
// Revision : 1.0
//==============================================================================
`default_nettype none

module fir_filter #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic         axis_clk,
  input  logic         axis_rst,
  fir_filter_if.slave  bus
);

  localparam logic [pADDR_WIDTH-1:0] A_CTRL = pADDR_WIDTH'('h00);
  localparam logic [pADDR_WIDTH-1:0] A_LEN  = pADDR_WIDTH'('h10);
  localparam logic [pADDR_WIDTH-1:0] A_TAP0 = pADDR_WIDTH'('h20);
  localparam logic [pADDR_WIDTH-1:0] A_TAPN = pADDR_WIDTH'('h48);
  localparam logic [3:0]             LAST_IDX = 4'd10;

  localparam logic [2:0] E_IDLE  = 3'd0;
  localparam logic [2:0] E_CLEAR = 3'd1;
  localparam logic [2:0] E_WAIT  = 3'd2;
  localparam logic [2:0] E_WRITE = 3'd3;
  localparam logic [2:0] E_MAC   = 3'd4;
  localparam logic [2:0] E_LAST  = 3'd5;
  localparam logic [2:0] E_OUT   = 3'd6;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_ISSUE = 2'd1;
  localparam logic [1:0] R_CAPT  = 2'd2;
  localparam logic [1:0] R_VALID = 2'd3;

  logic [2:0]             state_q, state_d;
  logic [1:0]             rstate_q, rstate_d;
  logic                   ap_start_q, ap_done_q, ap_idle_q;
  logic [pDATA_WIDTH-1:0] data_length_q, out_cnt_q, x_q, acc_q, sm_tdata_q, rdata_q;
  logic [3:0]             k_q, ptr_q, w_didx;
  logic                   last_q, mac_vld_q, sm_tvalid_q, sm_tlast_q;
  logic                   awready_q, arready_q, tap_rd_q;
  logic [pADDR_WIDTH-1:0] raddr_q;
  logic                   w_wr_go, w_tap_wr, w_rd_go, w_rd_tap, w_mac_issue;
  logic [pDATA_WIDTH-1:0] w_prod, w_ctrl;

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= A_TAP0) && (a <= A_TAPN) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [3:0] idx);
    return {{(pADDR_WIDTH-6){1'b0}}, idx, 2'b00};
  endfunction

  assign w_wr_go  = awready_q && bus.awvalid && bus.wvalid;
`ifdef FIR_TAP_LOCK_EN
  assign w_tap_wr = w_wr_go && is_tap(bus.awaddr) && ap_idle_q;
`else
  assign w_tap_wr = w_wr_go && is_tap(bus.awaddr);
`endif
  // A tap write owns the single tap RAM port; the MAC holds its index for that cycle.
  assign w_mac_issue = (state_q == E_MAC) && !w_tap_wr;
  assign w_rd_go     = (rstate_q == R_ISSUE) && !w_tap_wr;
  assign w_rd_tap    = w_rd_go && is_tap(raddr_q) && ap_idle_q;
  assign w_didx      = (ptr_q >= k_q) ? (ptr_q - k_q) : (ptr_q + 4'd11 - k_q);
  assign w_prod      = bus.tap_Do * bus.data_Do;
  assign w_ctrl      = {{(pDATA_WIDTH-3){1'b0}}, ap_idle_q, ap_done_q, ap_start_q};

  assign bus.awready   = awready_q;
  assign bus.wready    = awready_q;
  assign bus.arready   = arready_q;
  assign bus.rvalid    = (rstate_q == R_VALID);
  assign bus.rdata     = rdata_q;
  assign bus.sm_tvalid = sm_tvalid_q;
  assign bus.sm_tdata  = sm_tdata_q;
  assign bus.sm_tlast  = sm_tlast_q;

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q  <= E_IDLE;
      rstate_q <= R_IDLE;
    end else begin
      state_q  <= state_d;
      rstate_q <= rstate_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      E_IDLE:  if (ap_start_q) state_d = E_CLEAR;
      E_CLEAR: if (k_q == LAST_IDX) state_d = E_WAIT;
      E_WAIT:  if (bus.ss_tvalid) state_d = E_WRITE;
      E_WRITE: state_d = E_MAC;
      E_MAC:   if (w_mac_issue && k_q == LAST_IDX) state_d = E_LAST;
      E_LAST:  state_d = E_OUT;
      E_OUT:   if (bus.sm_tready) state_d = last_q ? E_IDLE : E_WAIT;
      default: state_d = E_IDLE;
    endcase
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (bus.arvalid) rstate_d = R_ISSUE;
      R_ISSUE: if (w_rd_go) rstate_d = R_CAPT;
      R_CAPT:  rstate_d = R_VALID;
      default: if (bus.rready) rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    bus.ss_tready = (state_q == E_WAIT);
    bus.data_EN   = 1'b0;
    bus.data_WE   = 4'h0;
    bus.data_A    = '0;
    bus.data_Di   = '0;
    case (state_q)
      E_CLEAR: begin
        bus.data_EN = 1'b1;
        bus.data_WE = 4'hF;
        bus.data_A  = word_addr(k_q);
      end
      E_WRITE: begin
        bus.data_EN = 1'b1;
        bus.data_WE = 4'hF;
        bus.data_A  = word_addr(ptr_q);
        bus.data_Di = x_q;
      end
      E_MAC: begin
        bus.data_EN = 1'b1;
        bus.data_A  = word_addr(w_didx);
      end
      default: ;
    endcase
    bus.tap_EN = 1'b0;
    bus.tap_WE = 4'h0;
    bus.tap_A  = '0;
    bus.tap_Di = '0;
    if (w_tap_wr) begin
      bus.tap_EN = 1'b1;
      bus.tap_WE = 4'hF;
      bus.tap_A  = bus.awaddr - A_TAP0;
      bus.tap_Di = bus.wdata;
    end else if (w_rd_tap) begin
      bus.tap_EN = 1'b1;
      bus.tap_A  = raddr_q - A_TAP0;
    end else if (w_mac_issue) begin
      bus.tap_EN = 1'b1;
      bus.tap_A  = word_addr(k_q);
    end
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      ap_start_q    <= 1'b0;
      ap_done_q     <= 1'b0;
      ap_idle_q     <= 1'b1;
      data_length_q <= '0;
      out_cnt_q     <= '0;
      x_q           <= '0;
      acc_q         <= '0;
      sm_tdata_q    <= '0;
      rdata_q       <= '0;
      k_q           <= '0;
      ptr_q         <= '0;
      last_q        <= 1'b0;
      mac_vld_q     <= 1'b0;
      sm_tvalid_q   <= 1'b0;
      sm_tlast_q    <= 1'b0;
      awready_q     <= 1'b0;
      arready_q     <= 1'b0;
      tap_rd_q      <= 1'b0;
      raddr_q       <= '0;
    end else begin
      awready_q <= bus.awvalid && bus.wvalid && !awready_q;
      arready_q <= (rstate_q == R_IDLE) && bus.arvalid;
      if (rstate_q == R_IDLE && bus.arvalid) raddr_q <= bus.araddr;
      if (w_rd_go) begin
        tap_rd_q <= w_rd_tap;
        if (raddr_q == A_CTRL) begin
          rdata_q   <= w_ctrl;
          ap_done_q <= 1'b0;
        end else if (raddr_q == A_LEN) begin
          rdata_q <= data_length_q;
        end else if (is_tap(raddr_q) && !ap_idle_q) begin
          rdata_q <= '1;
        end else begin
          rdata_q <= '0;
        end
      end
      if (rstate_q == R_CAPT && tap_rd_q) rdata_q <= bus.tap_Do;
      if (w_wr_go && bus.awaddr == A_CTRL && bus.wdata[0] && ap_idle_q) ap_start_q <= 1'b1;
      if (w_wr_go && bus.awaddr == A_LEN) data_length_q <= bus.wdata;

      mac_vld_q <= w_mac_issue;
      if (mac_vld_q) acc_q <= acc_q + w_prod;

      case (state_q)
        E_IDLE: begin
          k_q <= '0;
          if (ap_start_q) begin
            ap_start_q <= 1'b0;
            ap_done_q  <= 1'b0;
            ap_idle_q  <= 1'b0;
            ptr_q      <= '0;
            out_cnt_q  <= '0;
          end
        end
        E_CLEAR: k_q <= (k_q == LAST_IDX) ? 4'd0 : k_q + 4'd1;
        E_WAIT: if (bus.ss_tvalid) begin
          x_q    <= bus.ss_tdata;
          last_q <= bus.ss_tlast || (out_cnt_q + pDATA_WIDTH'(1) == data_length_q);
        end
        E_WRITE: begin
          k_q   <= '0;
          acc_q <= '0;
        end
        E_MAC: if (w_mac_issue) k_q <= k_q + 4'd1;
        E_LAST: begin
          // Final tap product is folded in here rather than waiting another cycle.
          sm_tdata_q  <= acc_q + w_prod;
          sm_tvalid_q <= 1'b1;
          sm_tlast_q  <= last_q;
          ptr_q       <= (ptr_q == LAST_IDX) ? 4'd0 : ptr_q + 4'd1;
        end
        E_OUT: if (bus.sm_tready) begin
          sm_tvalid_q <= 1'b0;
          sm_tlast_q  <= 1'b0;
          out_cnt_q   <= out_cnt_q + pDATA_WIDTH'(1);
          if (last_q) begin
            ap_done_q <= 1'b1;
            ap_idle_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_filter.sv
//==============================================================================
// Module   : tb_fir_filter
// Brief    : Directed self-checking bench for fir_filter with RAM models.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_fir_filter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_filter_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) bus ();

  fir_filter #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) dut (
    .axis_clk (clk),
    .axis_rst (rst),
    .bus      (bus.slave)
  );

  logic [31:0] tap_mem  [0:15];
  logic [31:0] data_mem [0:15];

  always @(posedge clk) begin
    if (bus.tap_EN) begin
      bus.tap_Do <= tap_mem[bus.tap_A[5:2]];
      if (bus.tap_WE == 4'hF) tap_mem[bus.tap_A[5:2]] <= bus.tap_Di;
    end
    if (bus.data_EN) begin
      bus.data_Do <= data_mem[bus.data_A[5:2]];
      if (bus.data_WE == 4'hF) data_mem[bus.data_A[5:2]] <= bus.data_Di;
    end
  end

  int n_asserts = 0;
  int n_fail    = 0;

  int taps [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
  int imp  [12] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0, 0};
  int cum  [11] = '{0, -10, -19, 4, 60, 123, 179, 202, 193, 183, 183};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    bus.awaddr = a; bus.wdata = d; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.awready && n < 20);
    check("aw_w_ready", {31'b0, bus.awready & bus.wready}, 32'd1);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
    int n = 0;
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.arready && n < 20);
    check("arready", {31'b0, bus.arready}, 32'd1);
    @(negedge clk);
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    n = 0;
    while (!bus.rvalid && n < 20) begin @(negedge clk); n++; end
    check("rvalid", {31'b0, bus.rvalid}, 32'd1);
    d = bus.rdata;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, d);
    check(tag, d, exp);
  endtask

  // Sends one sample, waits for its output, optionally stalls then acknowledges it.
  task automatic xfer(input string tag, input logic [31:0] x, input logic l,
                      input logic [31:0] exp, input logic exp_last,
                      input logic hold, input logic ack);
    int n = 0;
    int lat;
    @(negedge clk);
    bus.ss_tdata = x; bus.ss_tlast = l; bus.ss_tvalid = 1'b1;
    while (!bus.ss_tready && n < 100) begin @(negedge clk); n++; end
    check({tag, "_ss_tready"}, {31'b0, bus.ss_tready}, 32'd1);
    @(negedge clk);
    bus.ss_tvalid = 1'b0; bus.ss_tlast = 1'b0;
    lat = 1;
    while (!bus.sm_tvalid && lat < 30) begin @(negedge clk); lat++; end
    check({tag, "_latency_le_14"}, {31'b0, (lat <= 14)}, 32'd1);
    if (hold) begin
      repeat (20) @(negedge clk);
      check({tag, "_held_valid"}, {31'b0, bus.sm_tvalid}, 32'd1);
      check({tag, "_held_no_ready"}, {31'b0, bus.ss_tready}, 32'd0);
    end
    check(tag, bus.sm_tdata, exp);
    check({tag, "_tlast"}, {31'b0, bus.sm_tlast}, {31'b0, exp_last});
    if (ack) begin
      bus.sm_tready = 1'b1;
      @(negedge clk);
      bus.sm_tready = 1'b0;
      check({tag, "_valid_drop"}, {31'b0, bus.sm_tvalid}, 32'd0);
    end
  endtask

  task automatic run_impulse(input string tag);
    for (int i = 0; i < 12; i++) begin
      xfer($sformatf("%s_y%0d", tag, i), (i == 0) ? 32'd1 : 32'd0, 1'b0,
           32'(imp[i]), (i == 11), 1'b0, 1'b1);
      if (i == 4) begin
        logic [31:0] d;
        axi_read(12'h000, d);
        check({tag, "_midstream_ctrl"}, d & 32'hF, 32'd0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.awaddr = '0; bus.wdata = '0;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.rready = 1'b0;
    bus.ss_tvalid = 1'b0; bus.ss_tdata = '0; bus.ss_tlast = 1'b0;
    bus.sm_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", {31'b0, bus.awready}, 32'd0);
    check("rst_arready", {31'b0, bus.arready}, 32'd0);
    check("rst_rvalid", {31'b0, bus.rvalid}, 32'd0);
    check("rst_ss_tready", {31'b0, bus.ss_tready}, 32'd0);
    check("rst_sm_tvalid", {31'b0, bus.sm_tvalid}, 32'd0);
    check("rst_sm_tlast", {31'b0, bus.sm_tlast}, 32'd0);
    check("rst_ram_ctl", {22'b0, bus.tap_WE, bus.tap_EN, bus.data_WE, bus.data_EN}, 32'd0);
    rst = 1'b0;

    read_check("rst_ctrl", 12'h000, 32'h4);
    read_check("rst_len", 12'h010, 32'h0);

    for (int k = 0; k < 11; k++) axi_write(12'h020 + 12'(4 * k), 32'(taps[k]));
    for (int k = 0; k < 11; k++)
      read_check($sformatf("tap%0d", k), 12'h020 + 12'(4 * k), 32'(taps[k]));
    read_check("tap_0x48", 12'h048, 32'h0);
    read_check("unmapped_0x4C", 12'h04C, 32'h0);
    axi_write(12'h010, 32'd12);
    read_check("len_12", 12'h010, 32'd12);

    axi_write(12'h000, 32'h1);
    run_impulse("imp");
    read_check("done_ctrl", 12'h000, 32'h6);
    read_check("done_cleared", 12'h000, 32'h4);

    axi_write(12'h000, 32'h1);
    for (int i = 0; i < 11; i++) begin
      xfer($sformatf("ones_y%0d", i), 32'd1, (i == 10), 32'(cum[i]), (i == 10),
           (i == 5), 1'b1);
      if (i == 2) read_check("busy_tap_read", 12'h034, 32'hFFFF_FFFF);
    end
    read_check("ones_done_ctrl", 12'h000, 32'h6);
    read_check("ones_done_cleared", 12'h000, 32'h4);

    axi_write(12'h000, 32'h1);
    xfer("rst_y0", 32'd1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    xfer("rst_y1", 32'd0, 1'b0, 32'hFFFF_FFF6, 1'b0, 1'b0, 1'b1);
    xfer("rst_y2", 32'd0, 1'b0, 32'hFFFF_FFF7, 1'b0, 1'b0, 1'b1);
    xfer("rst_y3", 32'd0, 1'b0, 32'd23, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_sm_tvalid", {31'b0, bus.sm_tvalid}, 32'd0);
    check("midrst_ss_tready", {31'b0, bus.ss_tready}, 32'd0);
    read_check("midrst_ctrl", 12'h000, 32'h4);
    read_check("midrst_len", 12'h010, 32'h0);
    read_check("midrst_tap5", 12'h034, 32'd63);

    axi_write(12'h010, 32'd12);
    axi_write(12'h000, 32'h1);
    run_impulse("reimp");
    read_check("reimp_done_ctrl", 12'h000, 32'h6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
